// File: rtl/gcd_job_issuer_if.sv
// gcd_job_issuer_if: bundles the three handshakes around the GCD job issuer.
//   req_*  : operand-pair request (valid/ready, consumer is the issuer)
//   gcd_*  : engine go/done handshake (issuer drives operands and go)
//   rsp_*  : result response (valid/ready, producer is the issuer)
// Modports:
//   master : the issuer's view
//   slave  : the surrounding system's view (requester, engine, consumer)
interface gcd_job_issuer_if #(
   parameter int unsigned WIDTH = 8
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;

   logic [WIDTH-1:0] gcd_a;
   logic [WIDTH-1:0] gcd_b;
   logic             gcd_go;
   logic             gcd_done;
   logic [WIDTH-1:0] gcd_result;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_err;

   modport master (
      input  req_valid, req_a, req_b, gcd_done, gcd_result, rsp_ready,
      output req_ready, gcd_a, gcd_b, gcd_go, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      output req_valid, req_a, req_b, gcd_done, gcd_result, rsp_ready,
      input  req_ready, gcd_a, gcd_b, gcd_go, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/gcd_job_issuer.sv
// gcd_job_issuer: host-side initiator for the GCD engine's go/done handshake.
// Accepts an operand pair, issues a one-cycle go to the engine, waits for done
// (bounded by TIMEOUT cycles) and returns the result on the response port.
// Zero operands are answered directly, since the subtract-loop engine would
// never terminate on them.
// Ports:
//   clk           : system clock, all state on rising edge
//   rst           : synchronous active-high reset
//   bus           : request / engine / response handshakes (master view)
//   busy          : issuer is not idle
//   spurious_done : sticky, engine done seen outside the wait state
//   job_count     : number of responses delivered (wraps)
module gcd_job_issuer #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic                    clk,
   input  logic                    rst,
   gcd_job_issuer_if.master        bus,
   output logic                    busy,
   output logic                    spurious_done,
   output logic [15:0]             job_count
);

   localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e           state_q;
   logic [TW-1:0]    timer_q;
   logic [WIDTH-1:0] opa_q;
   logic [WIDTH-1:0] opb_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic             rsp_err_q;
   logic             rsp_valid_q;
   logic             gcd_go_q;
   logic             req_ready_q;
   logic             busy_q;
   logic             spurious_q;
   logic [15:0]      job_count_q;

   // All outputs are registered and updated alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         timer_q     <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         gcd_go_q    <= 1'b0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         spurious_q  <= 1'b0;
         job_count_q <= '0;
      end else begin
         // Any done outside WAIT (including a late one after a timeout) is
         // recorded but never used as data.
         if (bus.gcd_done && (state_q != StWait)) begin
            spurious_q <= 1'b1;
         end

         unique case (state_q)
            StIdle: begin
               if (bus.req_valid) begin
                  opa_q       <= bus.req_a;
                  opb_q       <= bus.req_b;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if ((bus.req_a == '0) || (bus.req_b == '0)) begin
                     // OR yields the nonzero operand, or zero when both are zero.
                     rsp_data_q  <= bus.req_a | bus.req_b;
                     rsp_err_q   <= (bus.req_a == '0) && (bus.req_b == '0);
                     rsp_valid_q <= 1'b1;
                     state_q     <= StResp;
                  end else begin
                     gcd_go_q <= 1'b1;
                     state_q  <= StIssue;
                  end
               end
            end

            StIssue: begin
               gcd_go_q <= 1'b0;
               timer_q  <= '0;
               state_q  <= StWait;
            end

            StWait: begin
               // done takes priority over an expiring timer on the same cycle.
               if (bus.gcd_done) begin
                  rsp_data_q  <= bus.gcd_result;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StResp;
               end else if (timer_q == TimerLast) begin
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StResp;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end

            StResp: begin
               if (bus.rsp_ready) begin
                  job_count_q <= job_count_q + 16'd1;
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.gcd_a      = opa_q;
   assign bus.gcd_b      = opb_q;
   assign bus.gcd_go     = gcd_go_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_err    = rsp_err_q;
   assign busy           = busy_q;
   assign spurious_done  = spurious_q;
   assign job_count      = job_count_q;

endmodule

// File: tb/tb_gcd_job_issuer.sv
// tb_gcd_job_issuer: randomized and directed checks of gcd_job_issuer against
// a job-level reference model, with a behavioural mock of the GCD engine.
module tb_gcd_job_issuer;
   localparam int unsigned WIDTH   = 8;
   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic        spurious_done;
   logic [15:0] job_count;

   gcd_job_issuer_if #(.WIDTH(WIDTH)) bus ();

   gcd_job_issuer #(
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .busy          (busy),
      .spurious_done (spurious_done),
      .job_count     (job_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   int exp_jobs = 0;
   bit exp_spur = 1'b0;

   // Mock engine control: eng_delay = cycles from go to done, 0 = never.
   int eng_delay = 0;
   int eng_cnt   = 0;
   int eng_res   = 0;
   int poke_req  = 0;
   int poke_seen = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_gcd(input int a, input int b);
      int x, y, r;
      x = a;
      y = b;
      while (y != 0) begin
         r = x % y;
         x = y;
         y = r;
      end
      return x;
   endfunction

   // Mock engine: done pulse eng_delay cycles after go, plus injected stray dones.
   initial begin
      bus.gcd_done   = 1'b0;
      bus.gcd_result = '0;
      forever begin
         step();
         bus.gcd_done   = 1'b0;
         bus.gcd_result = '0;
         if (rst) begin
            eng_cnt = 0;
         end else begin
            if (eng_cnt > 0) begin
               eng_cnt--;
               if (eng_cnt == 0) begin
                  bus.gcd_done   = 1'b1;
                  bus.gcd_result = WIDTH'(eng_res);
               end
            end
            if (bus.gcd_go && eng_delay > 0) begin
               eng_cnt = eng_delay;
               eng_res = ref_gcd(int'(bus.gcd_a), int'(bus.gcd_b));
            end
            if (poke_seen != poke_req) begin
               poke_seen      = poke_req;
               bus.gcd_done   = 1'b1;
               bus.gcd_result = 8'hAA;
            end
         end
      end
   end

   task automatic do_job(input int a, input int b, input int d, input int hold);
      int exp_data, exp_err, exp_lat, go_t, go_n, t;
      bit zero, run_ok, hold_ok;
      eng_delay = d;
      zero = (a == 0) || (b == 0);
      if (a == 0 && b == 0) begin
         exp_data = 0; exp_err = 1;
      end else if (zero) begin
         exp_data = a + b; exp_err = 0;
      end else if (d == 0) begin
         exp_data = 0; exp_err = 1;
      end else begin
         exp_data = ref_gcd(a, b); exp_err = 0;
      end
      // go at +1; response one cycle after done or after the last timer cycle.
      exp_lat = zero ? 1 : 2 + ((d == 0) ? int'(TIMEOUT) : d);

      t = 0;
      while (!bus.req_ready && t < 50) begin
         step();
         t++;
      end
      check_eq("req_ready_before_accept", 32'(bus.req_ready), 1);

      bus.req_valid = 1'b1;
      bus.req_a     = WIDTH'(a);
      bus.req_b     = WIDTH'(b);
      step();
      bus.req_valid = 1'b0;
      bus.req_a     = WIDTH'($urandom);
      bus.req_b     = WIDTH'($urandom);

      t = 1; go_t = -1; go_n = 0; run_ok = 1'b1;
      while (!bus.rsp_valid && t < 100) begin
         if (bus.gcd_go) begin
            go_n++;
            go_t = t;
         end
         if (bus.gcd_a !== WIDTH'(a) || bus.gcd_b !== WIDTH'(b) || bus.req_ready !== 1'b0 ||
             busy !== 1'b1) run_ok = 1'b0;
         step();
         t++;
      end
      check_eq("rsp_valid_seen", 32'(bus.rsp_valid), 1);
      check_eq("rsp_latency", 32'(t), 32'(exp_lat));
      check_eq("go_count", 32'(go_n), zero ? 0 : 1);
      check_eq("go_cycle", 32'(go_t), zero ? 32'hFFFF_FFFF : 1);
      check_eq("operands_stable", 32'(run_ok), 1);
      check_eq("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
      check_eq("rsp_err", 32'(bus.rsp_err), 32'(exp_err));

      // Backpressure: a competing request must not be taken while in RESP.
      hold_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         bus.req_valid = 1'b1;
         bus.req_a     = WIDTH'($urandom_range(1, 255));
         bus.req_b     = WIDTH'($urandom_range(1, 255));
         step();
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== WIDTH'(exp_data) ||
             bus.rsp_err !== 1'(exp_err) || bus.req_ready !== 1'b0 ||
             bus.gcd_a !== WIDTH'(a) || bus.gcd_go !== 1'b0) hold_ok = 1'b0;
      end
      check_eq("hold_stable", 32'(hold_ok), 1);

      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b0;
      exp_jobs++;
      check_eq("idle_rsp_valid", 32'(bus.rsp_valid), 0);
      check_eq("idle_req_ready", 32'(bus.req_ready), 1);
      check_eq("idle_busy", 32'(busy), 0);
      check_eq("idle_gcd_a", 32'(bus.gcd_a), 32'(a));
      check_eq("job_count", 32'(job_count), 32'(exp_jobs & 16'hFFFF));
      check_eq("spurious_done", 32'(spurious_done), 32'(exp_spur));
   endtask

   initial begin
      int ra, rb;
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      check_eq("rst_req_ready", 32'(bus.req_ready), 1);
      check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check_eq("rst_gcd_go", 32'(bus.gcd_go), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_spurious", 32'(spurious_done), 0);
      check_eq("rst_job_count", 32'(job_count), 0);
      check_eq("rst_gcd_ab", {16'd0, bus.gcd_a, bus.gcd_b}, 0);
      check_eq("rst_rsp", {23'd0, bus.rsp_err, bus.rsp_data}, 0);

      do_job(12, 18, 6, 0);     // basic job, result 6
      do_job(0, 7, 6, 0);       // zero operands
      do_job(9, 0, 6, 0);
      do_job(0, 0, 6, 0);
      do_job(5, 3, 0, 0);       // engine never done: timeout

      // Stray done in IDLE.
      poke_req++;
      exp_spur = 1'b1;
      step();
      step();
      step();
      check_eq("spurious_set", 32'(spurious_done), 1);
      check_eq("spurious_no_rsp", 32'(bus.rsp_valid), 0);

      do_job(12, 8, int'(TIMEOUT), 0);  // done on the last WAIT cycle wins
      do_job(21, 14, 3, 5);             // backpressure

      // Reset in the middle of WAIT.
      eng_delay     = 0;
      bus.req_valid = 1'b1;
      bus.req_a     = 8'd30;
      bus.req_b     = 8'd45;
      step();
      bus.req_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check_eq("mid_wait_busy", 32'(busy), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_jobs = 0;
      exp_spur = 1'b0;
      check_eq("midrst_req_ready", 32'(bus.req_ready), 1);
      check_eq("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
      check_eq("midrst_gcd_go", 32'(bus.gcd_go), 0);
      check_eq("midrst_job_count", 32'(job_count), 0);
      check_eq("midrst_spurious", 32'(spurious_done), 0);
      do_job(8, 12, 5, 0);

      for (int n = 0; n < 40; n++) begin
         ra = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255));
         rb = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255));
         do_job(ra, rb, int'($urandom_range(0, TIMEOUT)), int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
